// File: rtl/id_stage_pipe.sv
// RV32I decode stage: field decode, immediate generation, operand bypass, load-use detection, ID/EX register.
// Latency 1 cycle; stalls IF (id_ready_o=0) on load-use or when EX holds the bundle, flush overrides both.
module id_stage_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int REG_AW = 5,
    parameter bit BYP_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       inst_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic              if_valid_i,
    output logic              id_ready_o,
    output logic [REG_AW-1:0] reg1_addr_o,
    output logic [REG_AW-1:0] reg2_addr_o,
    input  logic [XLEN-1:0]   reg1_data_i,
    input  logic [XLEN-1:0]   reg2_data_i,
    input  logic              byp0_en_i,
    input  logic [REG_AW-1:0] byp0_rd_i,
    input  logic [XLEN-1:0]   byp0_data_i,
    input  logic              byp1_en_i,
    input  logic [REG_AW-1:0] byp1_rd_i,
    input  logic [XLEN-1:0]   byp1_data_i,
    input  logic              flush_i,
    input  logic              ex_ready_i,
    output logic              ex_valid_o,
    output logic [PC_W-1:0]   ex_pc_o,
    output logic [XLEN-1:0]   ex_rs1_data_o,
    output logic [XLEN-1:0]   ex_rs2_data_o,
    output logic [XLEN-1:0]   ex_imm_o,
    output logic [REG_AW-1:0] ex_wb_addr_o,
    output logic              ex_wb_en_o,
    output logic              ex_is_load_o,
    output logic [6:0]        ex_opcode_o,
    output logic [2:0]        ex_funct3_o,
    output logic [6:0]        ex_funct7_o,
    output logic              ex_illegal_o
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] wb_addr;
        logic              wb_en;
        logic              is_load;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic              illegal;
    } idex_t;

    logic [6:0]        opcode;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
    logic              wb_kind;
    logic              illegal;
    logic signed [31:0] imm32;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic              stall;
    logic              ex_valid;
    idex_t             id_d;
    idex_t             ex_q;

    assign opcode      = inst_i[6:0];
    assign rd          = REG_AW'(inst_i[11:7]);
    assign rs1         = REG_AW'(inst_i[19:15]);
    assign rs2         = REG_AW'(inst_i[24:20]);
    assign reg1_addr_o = rs1;
    assign reg2_addr_o = rs2;

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        wb_kind  = 1'b0;
        illegal  = 1'b0;
        imm32    = '0;
        case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                rs1_used = 1'b1;
                wb_kind  = 1'b1;
                imm32    = {{20{inst_i[31]}}, inst_i[31:20]};
            end
            OPC_STORE: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
            end
            OPC_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                imm32    = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
            end
            OPC_OP: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
                wb_kind  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                wb_kind = 1'b1;
                imm32   = {inst_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                wb_kind = 1'b1;
                imm32   = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
            end
            default: illegal = 1'b1;
        endcase
    end

    // x0 first, then the younger MEM result ahead of WB, then the regfile.
    always_comb begin
        rs1_val = reg1_data_i;
        if (rs1 == '0)
            rs1_val = '0;
        else if (BYP_EN && byp0_en_i && byp0_rd_i == rs1)
            rs1_val = byp0_data_i;
        else if (BYP_EN && byp1_en_i && byp1_rd_i == rs1)
            rs1_val = byp1_data_i;
    end

    always_comb begin
        rs2_val = reg2_data_i;
        if (rs2 == '0)
            rs2_val = '0;
        else if (BYP_EN && byp0_en_i && byp0_rd_i == rs2)
            rs2_val = byp0_data_i;
        else if (BYP_EN && byp1_en_i && byp1_rd_i == rs2)
            rs2_val = byp1_data_i;
    end

    always_comb begin
        id_d          = '0;
        id_d.pc       = pc_i;
        id_d.rs1_data = rs1_val;
        id_d.rs2_data = rs2_val;
        id_d.imm      = XLEN'(imm32);
        id_d.wb_addr  = rd;
        id_d.wb_en    = wb_kind && (rd != '0);
        id_d.is_load  = (opcode == OPC_LOAD);
        id_d.opcode   = opcode;
        id_d.funct3   = inst_i[14:12];
        id_d.funct7   = inst_i[31:25];
        id_d.illegal  = illegal;
    end

    assign stall = if_valid_i && ex_valid && ex_q.is_load && (ex_q.wb_addr != '0) &&
                   ((rs1_used && rs1 == ex_q.wb_addr) || (rs2_used && rs2 == ex_q.wb_addr));

    assign id_ready_o = flush_i || (!stall && (!ex_valid || ex_ready_i));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid <= 1'b0;
            ex_q     <= '0;
        end else if (flush_i) begin
            ex_valid <= 1'b0;
        end else if (ex_valid && !ex_ready_i) begin
            // EX has not taken the bundle: keep it frozen.
            ex_valid <= 1'b1;
        end else if (stall) begin
            ex_valid <= 1'b0;
        end else if (if_valid_i) begin
            ex_valid <= 1'b1;
            ex_q     <= id_d;
        end else begin
            ex_valid <= 1'b0;
        end
    end

    assign ex_valid_o    = ex_valid;
    assign ex_pc_o       = ex_q.pc;
    assign ex_rs1_data_o = ex_q.rs1_data;
    assign ex_rs2_data_o = ex_q.rs2_data;
    assign ex_imm_o      = ex_q.imm;
    assign ex_wb_addr_o  = ex_q.wb_addr;
    assign ex_wb_en_o    = ex_q.wb_en;
    assign ex_is_load_o  = ex_q.is_load;
    assign ex_opcode_o   = ex_q.opcode;
    assign ex_funct3_o   = ex_q.funct3;
    assign ex_funct7_o   = ex_q.funct7;
    assign ex_illegal_o  = ex_q.illegal;

endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
Parametrised decode stage for the RISC-V core, sitting between IF and EX.
- Decodes the RV32I instruction, drives the regfile read addresses and resolves operands through two bypass ports.
- Generates the immediate and write-back controls, and detects load-use hazards.
- Registers everything into an ID/EX pipeline register with a valid/ready handshake, flush and bubble insertion.

Parameters:
XLEN, 32, data/immediate width.
PC_W, 32, program-counter width.
REG_AW, 5, register address width.
BYP_EN, 1, 1 = bypass ports used; 0 = operands taken from the regfile only.

Ports:
clk  in  1  core clock
rst_n  in  1  synchronous active-low reset
inst_i  in  32  instruction from IF
pc_i  in  PC_W  PC of inst_i
if_valid_i  in  1  inst_i/pc_i valid
id_ready_o  out  1  ID accepts inst_i this cycle
reg1_addr_o  out  REG_AW  rs1 to regfile (combinational)
reg2_addr_o  out  REG_AW  rs2 to regfile (combinational)
reg1_data_i  in  XLEN  regfile rs1 data (combinational read)
reg2_data_i  in  XLEN  regfile rs2 data
byp0_en_i, byp0_rd_i, byp0_data_i  in  1/REG_AW/XLEN  MEM-stage bypass
byp1_en_i, byp1_rd_i, byp1_data_i  in  1/REG_AW/XLEN  WB-stage bypass
flush_i  in  1  branch/jump redirect; kill ID and ID/EX contents
ex_ready_i  in  1  EX accepts ID/EX bundle
ex_valid_o  out  1  ID/EX bundle valid
ex_pc_o  out  PC_W  registered PC
ex_rs1_data_o  out  XLEN  registered resolved rs1 operand
ex_rs2_data_o  out  XLEN  registered resolved rs2 operand
ex_imm_o  out  XLEN  registered sign-extended immediate
ex_wb_addr_o  out  REG_AW  registered rd
ex_wb_en_o  out  1  registered write-back enable
ex_is_load_o  out  1  registered LOAD flag
ex_opcode_o  out  7  registered opcode
ex_funct3_o  out  3  registered funct3
ex_funct7_o  out  7  registered funct7
ex_illegal_o  out  1  unsupported opcode

Behaviour:
- Reset (rst_n=0 at a clk edge): all ex_* outputs cleared to 0. id_ready_o is combinational, so it reads 1 after reset.
- Decode fields: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0], funct3=[14:12], funct7=[31:25]. reg1_addr_o/reg2_addr_o always equal rs1/rs2.
- Source usage:
  - rs1 is used by OP, OP-IMM, LOAD, STORE, BRANCH, JALR.
  - rs2 is used by OP, STORE, BRANCH.
  - An unused source never causes a stall.
- Immediate by format, sign-extended to XLEN:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH, with bit 0 = 0.
  - U: LUI, AUIPC, with low 12 bits = 0.
  - J: JAL, with bit 0 = 0.
  - OP and illegal opcodes: imm = 0.
- Write-back enable: wb_en = 1 for OP, OP-IMM, LOAD, LUI, AUIPC, JAL, JALR, and only when rd != 0.
- Illegal opcode: any other opcode sets illegal = 1 and forces wb_en = 0.
- Operand resolution, per source, first match wins:
  1. Address is x0 → value 0.
  2. byp0_en_i && byp0_rd_i == addr → byp0_data_i.
  3. byp1_en_i && byp1_rd_i == addr → byp1_data_i.
  4. Otherwise the regfile data.
  - With BYP_EN=0, only steps 1 and 4 apply.
- Load-use stall: stall = ex_valid_o && ex_is_load_o && ex_wb_addr_o != 0 && ((rs1 used && rs1 == ex_wb_addr_o) || (rs2 used && rs2 == ex_wb_addr_o)). Evaluated only when if_valid_i = 1.
- Ready: id_ready_o = flush_i || (!stall && (!ex_valid_o || ex_ready_i)).
- Register update, in priority order:
  1. flush_i: ex_valid_o <= 0. inst_i is accepted and dropped.
  2. ex_valid_o && !ex_ready_i: hold all ex_* (the bundle must stay stable while not accepted).
  3. stall: ex_valid_o <= 0 (bubble); inst_i is not accepted and IF holds it.
  4. if_valid_i: load the bundle, ex_valid_o <= 1.
  5. Otherwise: ex_valid_o <= 0.
- Flush plus stall in the same cycle: flush wins and no bubble-hold occurs.
- Reset mid-stall or mid-backpressure: everything clears next edge; no instruction is retained.
- Latency: exactly 1 cycle from acceptance to ex_valid_o. Throughput is 1 per cycle with no hazard.
- Operand data is captured at acceptance. Bypass changes after capture do not affect held bundles; EX-side forwarding covers that case.

Test Plan:
- Reset, then `addi x5,x0,-1` (0xFFF00293) valid → next cycle: ex_valid_o=1, ex_imm_o=0xFFFFFFFF, ex_wb_addr_o=5, ex_wb_en_o=1, ex_rs1_data_o=0.
- `lw x3,0(x1)` followed by `add x4,x3,x2` → add is held one cycle (id_ready_o=0), one bubble with ex_valid_o=0, then add issues. Repeat with `add x4,x6,x2`: no stall.
- Bypass priority: regfile x7=0x11, byp1 x7=0x22, byp0 x7=0x33, instruction `add x8,x7,x7` → both operands 0x33. Drop byp0 → 0x22. Use x0 as the source with byp0_rd=0 → 0.
- Backpressure: ex_ready_i=0 for 3 cycles with the bundle valid → ex_* stable, id_ready_o=0. Release → next instruction loads on the following edge.
- flush_i coincident with a load-use stall → ex_valid_o=0 next cycle, id_ready_o=1. The following instruction issues normally.
- Immediates:
  - `sw x2,-4(x1)` → imm 0xFFFFFFFC, wb_en 0.
  - `jal x1,+2048` → imm 0x00000800.
  - `lui x9,0x12345` → imm 0x12345000.
  - opcode 0x7F → illegal=1, wb_en=0.
